// File: rtl/hnf_snp_ctrl.sv
// HN-F snoop controller: fans one CHI snoop out to each sharer except the requester, then gathers SnpResp.
// Optional build macro HNF_SNP_BROADCAST_EN: ignore req_sharers and snoop every RN-F except the requester.
package hnf_snp_pkg;
  localparam int ADDR_W = 48;
  localparam int TXN_W  = 12;
  localparam int NODE_W = 7;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [TXN_W-1:0]  txn_id;
    logic [NODE_W-1:0] src_id;
  } reqflit_t;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [TXN_W-1:0]  txn_id;
    logic [NODE_W-1:0] tgt_id;
  } snpflit_t;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [NODE_W-1:0] src_id;
    logic [TXN_W-1:0]  txn_id;
    logic [2:0]        resp;
  } rspflit_t;

  localparam logic [6:0] REQ_READSHARED = 7'h01;
  localparam logic [6:0] REQ_READUNIQUE = 7'h07;
  localparam logic [4:0] SNP_SHARED     = 5'h01;
  localparam logic [4:0] SNP_UNIQUE     = 5'h07;
  localparam logic [4:0] RSP_SNPRESP    = 5'h01;
  // SnpRespData normally travels on DAT; its header is folded into this sink under a local code.
  localparam logic [4:0] RSP_SNPRESPDATA = 5'h1F;
  localparam int         RESP_PD_BIT     = 2;
endpackage

module hnf_snp_ctrl
  import hnf_snp_pkg::*;
#(
  parameter int NUM_RN     = 4,
  parameter int RN_ID_BASE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_v,
  output logic              req_ready,
  input  reqflit_t          req_flit,
  input  logic [NUM_RN-1:0] req_sharers,
  output logic              txsnp_v,
  input  logic              txsnp_ready,
  output snpflit_t          txsnp_flit,
  input  logic              rxrsp_v,
  output logic              rxrsp_ready,
  input  rspflit_t          rxrsp_flit,
  output logic              done_v,
  output logic              done_dirty,
  output logic              done_err
);

  localparam int IDX_W = (NUM_RN > 1) ? $clog2(NUM_RN) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [NUM_RN-1:0] pending_q, pending_nxt;
  logic [NUM_RN-1:0] resp_pend_q, resp_pend_nxt;
  logic              dirty_q, dirty_nxt, err_q, err_nxt;
  logic [4:0]        snp_op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TXN_W-1:0]  txn_q;

  logic [NUM_RN-1:0] base_mask, accept_mask, send_bit, send_set, rsp_bit;
  logic [IDX_W-1:0]  send_idx;
  logic              accept, snd_hs, rsp_hs, rsp_ok;

  function automatic logic [NUM_RN-1:0] node_bit(input logic [NODE_W-1:0] id);
    node_bit = '0;
    for (int i = 0; i < NUM_RN; i++)
      if (int'(id) == RN_ID_BASE + i) node_bit[i] = 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_RN-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_RN - 1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

`ifdef HNF_SNP_BROADCAST_EN
  logic unused_sharers;
  assign unused_sharers = ^req_sharers;
  assign base_mask      = '1;
`else
  assign base_mask = req_sharers;
`endif

  assign accept_mask = base_mask & ~node_bit(req_flit.src_id);
  assign accept      = req_v && req_ready;

  assign send_idx = lowest_idx(pending_q);
  assign send_bit = pending_q & ~(pending_q - NUM_RN'(1));
  assign snd_hs   = (state == SEND) && txsnp_ready;
  assign send_set = snd_hs ? send_bit : '0;

  // A response may retire a snoop handshaking in the same cycle, so the send is folded in first.
  assign rsp_hs = rxrsp_v && rxrsp_ready;
  assign rsp_bit = node_bit(rxrsp_flit.src_id);
  assign rsp_ok  = ((rxrsp_flit.opcode == RSP_SNPRESP) || (rxrsp_flit.opcode == RSP_SNPRESPDATA))
                   && (rxrsp_flit.txn_id == txn_q)
                   && (|(rsp_bit & (resp_pend_q | send_set)));

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending_q;
    resp_pend_nxt = resp_pend_q;
    dirty_nxt     = dirty_q;
    err_nxt       = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          pending_nxt   = accept_mask;
          resp_pend_nxt = '0;
          dirty_nxt     = 1'b0;
          err_nxt       = 1'b0;
          state_nxt     = (accept_mask == '0) ? DONE : SEND;
        end
      end
      SEND, WAIT: begin
        if (snd_hs) pending_nxt = pending_q & ~send_bit;
        resp_pend_nxt = resp_pend_q | send_set;
        if (rsp_hs) begin
          if (rsp_ok) begin
            resp_pend_nxt = resp_pend_nxt & ~rsp_bit;
            if (rxrsp_flit.resp[RESP_PD_BIT]) dirty_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        if (pending_nxt == '0) state_nxt = (resp_pend_nxt == '0) ? DONE : WAIT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      pending_q   <= '0;
      resp_pend_q <= '0;
      dirty_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending_q   <= pending_nxt;
      resp_pend_q <= resp_pend_nxt;
      dirty_q     <= dirty_nxt;
      err_q       <= err_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      snp_op_q <= (req_flit.opcode == REQ_READUNIQUE) ? SNP_UNIQUE : SNP_SHARED;
      addr_q   <= req_flit.addr;
      txn_q    <= req_flit.txn_id;
    end
  end

  assign req_ready   = (state == IDLE);
  assign rxrsp_ready = reset;
  assign txsnp_v     = (state == SEND);
  assign txsnp_flit  = '{opcode: snp_op_q, addr: addr_q, txn_id: txn_q,
                         tgt_id: NODE_W'(RN_ID_BASE + int'(send_idx))};
  assign done_v      = (state == DONE);
  assign done_dirty  = done_v && dirty_q;
  assign done_err    = done_v && err_q;

endmodule

// File: tb/tb_hnf_snp_ctrl.sv
// Scoreboard bench for hnf_snp_ctrl: directed jobs push expected snoops/completions, a monitor pops and compares.
module tb_hnf_snp_ctrl;
  import hnf_snp_pkg::*;

  logic     clock = 1'b0;
  logic     reset;
  logic     req_v, req_ready;
  reqflit_t req_flit;
  logic [3:0] req_sharers;
  logic     txsnp_v, txsnp_ready;
  snpflit_t txsnp_flit;
  logic     rxrsp_v, rxrsp_ready;
  rspflit_t rxrsp_flit;
  logic     done_v, done_dirty, done_err;

  int checks = 0;
  int failures = 0;

  snpflit_t   exp_snp[$];
  logic [1:0] exp_done[$];

  hnf_snp_ctrl #(.NUM_RN(4), .RN_ID_BASE(0)) dut (
    .clock(clock), .reset(reset),
    .req_v(req_v), .req_ready(req_ready), .req_flit(req_flit), .req_sharers(req_sharers),
    .txsnp_v(txsnp_v), .txsnp_ready(txsnp_ready), .txsnp_flit(txsnp_flit),
    .rxrsp_v(rxrsp_v), .rxrsp_ready(rxrsp_ready), .rxrsp_flit(rxrsp_flit),
    .done_v(done_v), .done_dirty(done_dirty), .done_err(done_err)
  );

  always #5 clock = ~clock;

  function automatic snpflit_t mk_snp(input logic [4:0] op, input logic [47:0] a,
                                      input logic [11:0] t, input logic [6:0] tgt);
    mk_snp = '{opcode: op, addr: a, txn_id: t, tgt_id: tgt};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Monitor: every snoop handshake and completion pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (txsnp_v && txsnp_ready) begin
        checks++;
        if (exp_snp.size() == 0) begin
          failures++;
          $display("FAIL snp_unexpected got=%h required=none", txsnp_flit);
        end else begin
          snpflit_t e;
          e = exp_snp.pop_front();
          if (txsnp_flit !== e) begin
            failures++;
            $display("FAIL snp_flit got=%h required=%h", txsnp_flit, e);
          end
        end
      end
      if (done_v) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected got dirty=%0b err=%0b required=none", done_dirty, done_err);
        end else begin
          logic [1:0] d;
          d = exp_done.pop_front();
          if ({done_dirty, done_err} !== d) begin
            failures++;
            $display("FAIL done_status got={dirty,err}=%b required=%b", {done_dirty, done_err}, d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("wait_ready_bound", req_ready, 1);
  endtask

  task automatic accept(input logic [6:0] op, input logic [6:0] src, input logic [11:0] txn,
                        input logic [47:0] a, input logic [3:0] sh);
    wait_ready();
    req_flit    = '{opcode: op, addr: a, txn_id: txn, src_id: src};
    req_sharers = sh;
    req_v       = 1'b1;
    tick();
    req_v = 1'b0;
  endtask

  task automatic rsp(input logic [4:0] op, input logic [6:0] src, input logic [11:0] txn,
                     input logic [2:0] r);
    rxrsp_flit = '{opcode: op, src_id: src, txn_id: txn, resp: r};
    rxrsp_v    = 1'b1;
    tick();
    rxrsp_v = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_txsnp_v"}, txsnp_v, 0);
    chk({tag, "_rxrsp_ready"}, rxrsp_ready, 0);
    chk({tag, "_done_v"}, {done_v, done_dirty, done_err}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    snpflit_t held;
    reset = 1'b0; req_v = 1'b0; txsnp_ready = 1'b1; rxrsp_v = 1'b0;
    req_flit = '0; req_sharers = '0; rxrsp_flit = '0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();
    chk("rxrsp_ready_up", rxrsp_ready, 1);

    // Job 1: ReadShared from RN0, sharers RN1/RN2; each response lands with its own snoop.
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h1000, 12'h011, 7'd1));
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h1000, 12'h011, 7'd2));
    exp_done.push_back(2'b00);
    accept(REQ_READSHARED, 7'd0, 12'h011, 48'h1000, 4'b0110);
    chk("j1_first_snp_cycle1", txsnp_v, 1);
    rsp(RSP_SNPRESP, 7'd1, 12'h011, 3'b000);
    rsp(RSP_SNPRESP, 7'd2, 12'h011, 3'b000);
    chk("j1_done_after_last_rsp", done_v, 1);
    wait_ready();

    // Job 2: only the requester shares the line, so nothing is snooped.
    exp_done.push_back(2'b00);
    accept(REQ_READUNIQUE, 7'd0, 12'h012, 48'h1040, 4'b0001);
    chk("j2_done_cycle1", done_v, 1);
    chk("j2_no_snoop", txsnp_v, 0);
    wait_ready();

    // Job 3: ReadUnique to RN1/RN3 with TXSNP stalled 3 cycles; RN3 passes dirty.
    txsnp_ready = 1'b0;
    exp_snp.push_back(mk_snp(SNP_UNIQUE, 48'h2040, 12'h022, 7'd1));
    exp_snp.push_back(mk_snp(SNP_UNIQUE, 48'h2040, 12'h022, 7'd3));
    exp_done.push_back(2'b10);
    accept(REQ_READUNIQUE, 7'd0, 12'h022, 48'h2040, 4'b1010);
    chk("j3_snp_valid", txsnp_v, 1);
    held = txsnp_flit;
    chk("j3_held_tgt", held.tgt_id, 1);
    chk("j3_held_op", held.opcode, SNP_UNIQUE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("j3_stall_stable", (txsnp_flit === held) && txsnp_v, 1);
    end
    txsnp_ready = 1'b1;
    tick();
    tick();
    chk("j3_waiting", req_ready, 0);
    rsp(RSP_SNPRESP, 7'd1, 12'h022, 3'b000);
    rsp(RSP_SNPRESPDATA, 7'd3, 12'h022, 3'b100);
    wait_ready();

    // Job 4: requester RN1 masked; wrong TxnID and a duplicate both flag err.
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h3000, 12'h033, 7'd2));
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h3000, 12'h033, 7'd3));
    exp_done.push_back(2'b01);
    accept(REQ_READSHARED, 7'd1, 12'h033, 48'h3000, 4'b1110);
    tick();
    tick();
    rsp(RSP_SNPRESP, 7'd2, 12'h034, 3'b000);
    rsp(RSP_SNPRESP, 7'd2, 12'h033, 3'b000);
    rsp(RSP_SNPRESP, 7'd2, 12'h033, 3'b000);
    chk("j4_still_waiting", {req_ready, done_v}, 2'b00);
    rsp(RSP_SNPRESP, 7'd3, 12'h033, 3'b000);
    wait_ready();

    // Job 5: reset while waiting on RN1, then a stale response arrives.
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h4000, 12'h044, 7'd1));
    accept(REQ_READSHARED, 7'd0, 12'h044, 48'h4000, 4'b0010);
    tick();
    chk("j5_in_wait", req_ready, 0);
    reset = 1'b0;
    tick();
    chk_reset_outputs("j5_rst");
    tick();
    reset = 1'b1;
    tick();
    rsp(RSP_SNPRESP, 7'd1, 12'h044, 3'b100);
    for (int i = 0; i < 3; i++) begin
      chk("j5_no_done", done_v, 0);
      tick();
    end
    chk("j5_idle", req_ready, 1);

`ifdef HNF_SNP_BROADCAST_EN
    // Job 6: broadcast ignores the empty sharer vector, skipping requester RN2.
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h5000, 12'h055, 7'd0));
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h5000, 12'h055, 7'd1));
    exp_snp.push_back(mk_snp(SNP_SHARED, 48'h5000, 12'h055, 7'd3));
    exp_done.push_back(2'b00);
    accept(REQ_READSHARED, 7'd2, 12'h055, 48'h5000, 4'b0000);
    tick();
    tick();
    tick();
    rsp(RSP_SNPRESP, 7'd0, 12'h055, 3'b000);
    rsp(RSP_SNPRESP, 7'd1, 12'h055, 3'b000);
    rsp(RSP_SNPRESP, 7'd3, 12'h055, 3'b000);
    wait_ready();
`else
    // Job 6: empty sharer vector completes without snoops.
    exp_done.push_back(2'b00);
    accept(REQ_READSHARED, 7'd2, 12'h055, 48'h5000, 4'b0000);
    chk("j6_done_cycle1", done_v, 1);
    wait_ready();
`endif

    repeat (3) tick();
    chk("snp_queue_drained", exp_snp.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
